hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage core. It produces the stall, flush and forwarding controls for the fetch, decode, execute and memory pipeline registers, including the FlushE input of the decode/execute register. It combines combinational RAW-hazard detection with a sequential data-memory wait FSM, a wait timeout and a stall-cycle performance counter.

---
 rtl/hazard_if.sv | 34 +++
 rtl/hazard_unit.sv | 139 +++++++++++++
 tb/tb_hazard_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard controller bundle: pipeline-stage register fields in, stall/flush/forward controls out.
interface hazard_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           Rs1D, Rs2D;
    logic [4:0]           Rs1E, Rs2E;
    logic [4:0]           RdE, RdM, RdW;
    logic                 RegWriteM, RegWriteW;
    logic [1:0]           ResultSrcE;
    logic                 PCSrcE;
    logic                 MemReqM;
    logic                 MemReadyM;
    logic                 StallF, StallD, StallE, StallM;
    logic                 FlushD, FlushE;
    logic [1:0]           ForwardAE, ForwardBE;
    logic                 MemErr;
    logic [CNT_WIDTH-1:0] StallCount;

    // Pipeline side: supplies stage fields, consumes the controls.
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE,
        input  ForwardAE, ForwardBE, MemErr, StallCount
    );

    // Hazard unit side.
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE,
        output ForwardAE, ForwardBE, MemErr, StallCount
    );
endinterface

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard controller: combinational forwarding and load-use
// detection, a data-memory wait FSM with timeout, and a saturating stall counter.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave hz
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR} mstate_t;

    localparam logic [8:0] TIMEOUT_L = 9'(MEM_TIMEOUT);

    mstate_t              state_q, state_d;
    logic [7:0]           wait_q, wait_d;
    logic [8:0]           wait_next;
    logic                 mem_stall;
    logic                 load_stall;
    logic                 stall_f;
    logic [CNT_WIDTH-1:0] stall_count;

    // Writeback/memory bypass select; memory stage wins, x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m, input logic we_m,
        input logic [4:0] rd_w, input logic we_w
    );
        if (we_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (we_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v)
            return v;
        else
            return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    assign wait_next  = {1'b0, wait_q} + 9'd1;
    assign load_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    // Memory FSM state and wait counter; reset drops straight back to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Memory FSM next state and the memory stall request.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hz.MemReqM && !hz.MemReadyM) begin
                    mem_stall = 1'b1;
                    wait_d    = 8'd1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only the ready strobe ends a wait; a dropped request is ignored.
                mem_stall = !hz.MemReadyM;
                if (hz.MemReadyM)
                    state_d = S_IDLE;
                else if (wait_next == TIMEOUT_L)
                    state_d = S_ERR;
                else
                    wait_d = wait_next[7:0];
            end
            S_ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Priority chain: memory stall, then taken branch, then load-use bubble.
    always_comb begin
        hz.StallF = 1'b0;
        hz.StallD = 1'b0;
        hz.StallE = 1'b0;
        hz.StallM = 1'b0;
        hz.FlushD = 1'b0;
        hz.FlushE = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
            end else if (hz.PCSrcE) begin
                hz.FlushD = 1'b1;
                hz.FlushE = 1'b1;
            end else if (load_stall) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.FlushE = 1'b1;
            end
        end
    end

    // Operand bypass selects, held at register-file while in reset.
    always_comb begin
        hz.ForwardAE = 2'b00;
        hz.ForwardBE = 2'b00;
        if (!rst) begin
            hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
            hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
        end
    end

    assign stall_f = hz.StallF;

    // Stall-cycle performance counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stall_f)
            stall_count <= sat_inc(stall_count);
    end

    assign hz.MemErr     = (state_q == S_ERR);
    assign hz.StallCount = stall_count;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a vector table for the combinational controls
// plus hand sequences for load-use counting, memory waits, timeout and reset.
module tb_hazard_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    hazard_if #(.CNT_WIDTH(32)) hz ();

    hazard_unit #(.MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww;
        logic [1:0] rsrc;
        logic       pcsrc, memreq, memrdy;
        logic [5:0] ctl;   // {StallF,StallD,StallE,StallM,FlushD,FlushE}
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] ctl_now();
        return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE};
    endfunction

    task automatic clear_inputs();
        hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
        hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE = 2'b00;
        hz.PCSrcE = 1'b0; hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e; hz.Rs2E = v.rs2e;
        hz.RdE = v.rde; hz.RdM = v.rdm; hz.RdW = v.rdw;
        hz.RegWriteM = v.rwm; hz.RegWriteW = v.rww; hz.ResultSrcE = v.rsrc;
        hz.PCSrcE = v.pcsrc; hz.MemReqM = v.memreq; hz.MemReadyM = v.memrdy;
    endtask

    initial begin
        int n_stall;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();

        //                 rs1d  rs2d  rs1e  rs2e  rde   rdm   rdw   rwm   rww   rsrc   pc    req   rdy   ctl        fa     fb
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b10, 2'b00};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b01, 2'b00};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00};
        vecs[4]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd9, 5'd3, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b01, 2'b10};
        vecs[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 6'b110001, 2'b00, 2'b00};
        vecs[6]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 6'b110001, 2'b00, 2'b00};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00};
        vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00};
        vecs[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00};
        vecs[10] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 6'b000011, 2'b00, 2'b00};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 6'b000011, 2'b00, 2'b00};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 6'b000000, 2'b00, 2'b00};
        vecs[13] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 6'b110001, 2'b00, 2'b00};
        vecs[14] = '{5'd8, 5'd0, 5'd4, 5'd6, 5'd8, 5'd4, 5'd6, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 6'b110001, 2'b10, 2'b01};
        vecs[15] = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00};

        // Reset state with every hazard source active.
        @(negedge clk);
        hz.Rs2D = 5'd7; hz.RdE = 5'd7; hz.ResultSrcE = 2'b01; hz.PCSrcE = 1'b1;
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
        #1;
        check("rst_ctl", 32'(ctl_now()), 32'h0);
        check("rst_fwdA", 32'(hz.ForwardAE), 32'h0);
        check("rst_memerr", 32'(hz.MemErr), 32'h0);
        check("rst_count", hz.StallCount, 32'h0);

        // Vector table.
        do_reset();
        n_stall = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            apply_vec(vecs[i]);
            #1;
            check($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            check($sformatf("vec%0d_fwdA", i), 32'(hz.ForwardAE), 32'(vecs[i].fa));
            check($sformatf("vec%0d_fwdB", i), 32'(hz.ForwardBE), 32'(vecs[i].fb));
            if (vecs[i].ctl[5]) n_stall++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        check("vec_count", hz.StallCount, 32'(n_stall));

        // Load-use bubble lasts one cycle and counts once.
        do_reset();
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        #1;
        check("lu_ctl", 32'(ctl_now()), 32'h31);
        @(negedge clk);
        clear_inputs();
        #1;
        check("lu_release", 32'(ctl_now()), 32'h0);
        check("lu_count", hz.StallCount, 32'd1);

        // Memory wait: three not-ready cycles, then ready.
        do_reset();
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mw_stall%0d", i), 32'(ctl_now()), 32'h3C);
            @(negedge clk);
        end
        hz.MemReadyM = 1'b1;
        #1;
        check("mw_release", 32'(ctl_now()), 32'h0);
        @(negedge clk);
        hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
        #1;
        check("mw_idle", 32'(ctl_now()), 32'h0);
        check("mw_count", hz.StallCount, 32'd3);

        // Memory wait with a taken branch held throughout.
        do_reset();
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0; hz.PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mwb_stall%0d", i), 32'(ctl_now()), 32'h3C);
            @(negedge clk);
        end
        hz.MemReadyM = 1'b1;
        #1;
        check("mwb_release", 32'(ctl_now()), 32'h03);
        @(negedge clk);
        clear_inputs();
        #1;
        check("mwb_count", hz.StallCount, 32'd3);

        // Request dropped mid-wait keeps the stall until ready.
        do_reset();
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
        @(negedge clk);
        hz.MemReqM = 1'b0;
        #1;
        check("drop_stall", 32'(ctl_now()), 32'h3C);
        @(negedge clk);
        hz.MemReadyM = 1'b1;
        #1;
        check("drop_release", 32'(ctl_now()), 32'h0);

        // Timeout: sixteen stalled cycles, then sticky error.
        do_reset();
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("to_stall%0d", i), 32'(ctl_now()), 32'h3C);
            check($sformatf("to_noerr%0d", i), 32'(hz.MemErr), 32'h0);
            @(negedge clk);
        end
        #1;
        check("to_err", 32'(hz.MemErr), 32'h1);
        check("to_count", hz.StallCount, 32'd16);
        hz.MemReadyM = 1'b1;
        #1;
        check("to_err_stall", 32'(ctl_now()), 32'h3C);
        @(negedge clk);
        #1;
        check("to_err_sticky", 32'(hz.MemErr), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("to_rst_err", 32'(hz.MemErr), 32'h0);
        check("to_rst_count", hz.StallCount, 32'h0);
        check("to_rst_ctl", 32'(ctl_now()), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        hz.MemReqM = 1'b1; hz.MemReadyM = 1'b1;
        #1;
        check("to_after_rst", 32'(ctl_now()), 32'h0);
        @(negedge clk);
        hz.MemReadyM = 1'b0; hz.MemReqM = 1'b0;
        #1;
        check("ready_first_no_state", 32'(ctl_now()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
